// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, word width,
// opcode field position and the default reset PC.
package mips_pkg;

    localparam int WORD_W    = 32;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] INSTR_BYTES      = 32'd4;

    // FETCH: request on the bus, WAIT: awaiting our response,
    // HOLD: instruction presented to decode, DROP: awaiting a stale response
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Performance counters for the fetch stage: instructions handed to decode
// and instructions/responses thrown away by redirects. Both wrap at 2^32.
module fetch_perf_cnt
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_event,
    input  logic              flush_event,
    output logic [WORD_W-1:0] fetched,
    output logic [WORD_W-1:0] flushed
);

    // Count each event once per cycle; natural overflow gives the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched <= '0;
            flushed <= '0;
        end else begin
            if (fetch_event) begin
                fetched <= fetched + 32'd1;
            end
            if (flush_event) begin
                flushed <= flushed + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a single held
// instruction for decode, and branch redirect with stale-response dropping.
// Optional feature macro: FETCH_PERF_CNT_EN enables the performance counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORD_W-1:0]   imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [WORD_W-1:0]   imem_rsp_data,
    input  logic                branch_taken,
    input  logic [WORD_W-1:0]   branch_target,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [WORD_W-1:0]   if_instr,
    output logic [OPCODE_W-1:0] if_opcode,
    output logic [WORD_W-1:0]   if_pc4,
    output logic [WORD_W-1:0]   perf_fetched,
    output logic [WORD_W-1:0]   perf_flushed
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [WORD_W-1:0] pc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a redirect overrides response capture and id_ready
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (imem_req_ready) begin
                    next_state = branch_taken ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    next_state = imem_rsp_valid ? FETCH : DROP;
                end else if (imem_rsp_valid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken || id_ready) begin
                    next_state = FETCH;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // Bus outputs; the request is suppressed while reset is asserted
    always_comb begin
        imem_req_valid = (state == FETCH) && !reset;
        imem_addr      = pc;
    end

    assign if_opcode = if_instr[OPCODE_HI:OPCODE_LO];

    // PC and held-instruction registers; a redirect flushes the held word
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc4   <= '0;
        end else if (branch_taken) begin
            pc       <= align_word(branch_target);
            if_valid <= 1'b0;
        end else if ((state == WAIT) && imem_rsp_valid) begin
            pc       <= pc + INSTR_BYTES;
            if_valid <= 1'b1;
            if_instr <= imem_rsp_data;
            if_pc4   <= pc + INSTR_BYTES;
        end else if ((state == HOLD) && id_ready) begin
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_event;
    logic flush_event;

    // A flush is either a held instruction killed by a redirect or a
    // response that arrives but is never presented to decode
    always_comb begin
        fetch_event = if_valid && id_ready;
        flush_event = ((state == HOLD) && if_valid && branch_taken)
                   || ((state == WAIT) && imem_rsp_valid && branch_taken)
                   || ((state == DROP) && imem_rsp_valid);
    end

    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .reset       (reset),
        .fetch_event (fetch_event),
        .flush_event (flush_event),
        .fetched     (perf_fetched),
        .flushed     (perf_flushed)
    );
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, randomized run against
// a transaction-level reference model, and a wrap-around reset PC instance.
module tb_fetch_stage;

    localparam logic [31:0] I0 = 32'h8C01_0000;
    localparam logic [31:0] I1 = 32'h2002_0005;
    localparam logic [31:0] I2 = 32'h0043_1820;
    localparam logic [31:0] GB = 32'hDEAD_BEEF;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] data;
        bit          br;
        logic [31:0] target;
        bit          idr;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default reset PC)
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc4;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    // Wrap-around instance (reset PC at the top of the address space)
    logic        w_reset = 1'b1;
    logic        w_req_valid;
    logic        w_req_ready = 1'b0;
    logic [31:0] w_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_id_ready = 1'b0;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [5:0]  w_if_opcode;
    logic [31:0] w_if_pc4;
    logic [31:0] w_perf_fetched;
    logic [31:0] w_perf_flushed;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc4         (if_pc4),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (w_reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .branch_taken   (1'b0),
        .branch_target  (32'h0),
        .id_ready       (w_id_ready),
        .if_valid       (w_if_valid),
        .if_instr       (w_if_instr),
        .if_opcode      (w_if_opcode),
        .if_pc4         (w_if_pc4),
        .perf_fetched   (w_perf_fetched),
        .perf_flushed   (w_perf_flushed)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Reference model: outstanding request, whether its response is stale,
    // and the instruction currently offered to decode
    logic [31:0] m_pc      = '0;
    logic [31:0] m_instr   = '0;
    logic [31:0] m_pc4     = '0;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_flushed = '0;
    bit          m_hv      = 1'b0;
    bit          m_out     = 1'b0;
    bit          m_poison  = 1'b0;

    logic        pre_rv;
    logic [31:0] pre_addr;

    vec_t tbl[$];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic modelUpdate();
        bit fire;
        bit take;
        bit nxt_out;
        if (reset) begin
            m_pc = 32'h0; m_instr = '0; m_pc4 = '0;
            m_fetched = '0; m_flushed = '0;
            m_hv = 1'b0; m_out = 1'b0; m_poison = 1'b0;
        end else begin
            fire = !m_hv && !m_out && imem_req_ready;
            take = m_out && imem_rsp_valid;
            if (m_hv && id_ready) m_fetched = m_fetched + 1;
            if ((m_hv && branch_taken) || (take && (m_poison || branch_taken)))
                m_flushed = m_flushed + 1;
            nxt_out = fire || (m_out && !imem_rsp_valid);
            if (branch_taken) begin
                m_pc     = branch_target & ~32'h3;
                m_hv     = 1'b0;
                m_poison = nxt_out;
            end else begin
                if (take && !m_poison) begin
                    m_hv    = 1'b1;
                    m_instr = imem_rsp_data;
                    m_pc4   = m_pc + 32'd4;
                    m_pc    = m_pc + 32'd4;
                end else if (m_hv && id_ready) begin
                    m_hv = 1'b0;
                end
                m_poison = nxt_out && m_poison;
            end
            m_out = nxt_out;
        end
    endtask

    task automatic checkOutput(input bit pre);
        logic [31:0] e_fetched;
        logic [31:0] e_flushed;
        logic [31:0] e_instr;
        if (pre) begin
            checkVal("req_valid", {31'd0, imem_req_valid}, {31'd0, !reset && !m_hv && !m_out});
            checkVal("imem_addr", imem_addr, m_pc);
        end else begin
            e_instr = m_instr;
`ifdef FETCH_PERF_CNT_EN
            e_fetched = m_fetched;
            e_flushed = m_flushed;
`else
            e_fetched = '0;
            e_flushed = '0;
`endif
            checkVal("if_valid", {31'd0, if_valid}, {31'd0, m_hv});
            checkVal("if_instr", if_instr, e_instr);
            checkVal("if_opcode", {26'd0, if_opcode}, {26'd0, e_instr[31:26]});
            checkVal("if_pc4", if_pc4, m_pc4);
            checkVal("perf_fetched", perf_fetched, e_fetched);
            checkVal("perf_flushed", perf_flushed, e_flushed);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rdy, input bit rv, input logic [31:0] data,
                                 input bit br, input logic [31:0] target, input bit idr);
        @(negedge clk);
        reset          = rst;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = data;
        branch_taken   = br;
        branch_target  = target;
        id_ready       = idr;
        #1;
        pre_rv   = imem_req_valid;
        pre_addr = imem_addr;
        if (checking) checkOutput(1'b1);
        @(posedge clk);
        modelUpdate();
        #1;
        if (checking) checkOutput(1'b0);
    endtask

    function automatic vec_t mkv(input bit rst, input bit rdy, input bit rv, input logic [31:0] d,
                                 input bit br, input logic [31:0] t, input bit idr,
                                 input bit erv, input logic [31:0] ea, input bit ev,
                                 input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.data = d; v.br = br; v.target = t; v.idr = idr;
        v.e_rv = erv; v.e_addr = ea; v.e_v = ev; v.e_instr = ei; v.e_pc4 = ep;
        return v;
    endfunction

    initial begin
        // rst rdy rv data br target idr | req addr valid instr pc4
        tbl.push_back(mkv(1,0,0,0 ,0,0,0, 0,32'h0  ,0,0 ,32'h0));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h0  ,0,0 ,32'h0));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 0,32'h0  ,0,0 ,32'h0));
        tbl.push_back(mkv(0,0,1,I0,0,0,1, 0,32'h0  ,1,I0,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,0,0,1, 0,32'h4  ,0,I0,32'h4));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h4  ,0,I0,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 0,32'h4  ,0,I0,32'h4));
        tbl.push_back(mkv(0,0,1,I1,0,0,0, 0,32'h4  ,1,I1,32'h8));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkv(0,1,0,0,0,0,0, 0,32'h8,1,I1,32'h8));
        tbl.push_back(mkv(0,0,0,0 ,0,0,1, 0,32'h8  ,0,I1,32'h8));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h8  ,0,I1,32'h8));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 0,32'h8  ,0,I1,32'h8));
        tbl.push_back(mkv(0,0,1,I2,0,0,1, 0,32'h8  ,1,I2,32'hC));
        tbl.push_back(mkv(0,0,0,0 ,0,0,1, 0,32'hC  ,0,I2,32'hC));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'hC  ,0,I2,32'hC));
        tbl.push_back(mkv(0,0,0,0 ,1,32'h103,0, 0,32'hC  ,0,I2,32'hC));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 0,32'h100,0,I2,32'hC));
        tbl.push_back(mkv(0,0,1,GB,0,0,0, 0,32'h100,0,I2,32'hC));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h100,0,I2,32'hC));
        tbl.push_back(mkv(0,0,1,GB,1,32'h200,0, 0,32'h100,0,I2,32'hC));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h200,0,I2,32'hC));
        tbl.push_back(mkv(0,0,1,I0,0,0,0, 0,32'h200,1,I0,32'h204));
        tbl.push_back(mkv(0,0,0,0 ,1,32'h40,1, 0,32'h204,0,I0,32'h204));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h40 ,0,I0,32'h204));
        tbl.push_back(mkv(1,0,0,0 ,0,0,0, 0,32'h40 ,0,0 ,32'h0));
        tbl.push_back(mkv(0,0,1,GB,0,0,0, 1,32'h0  ,0,0 ,32'h0));
        tbl.push_back(mkv(0,1,0,0 ,0,0,0, 1,32'h0  ,0,0 ,32'h0));
        tbl.push_back(mkv(0,0,1,I1,0,0,0, 0,32'h0  ,1,I1,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,0,0,1, 0,32'h4  ,0,I1,32'h4));
        tbl.push_back(mkv(0,1,0,0 ,1,32'h80,0, 1,32'h4  ,0,I1,32'h4));
        tbl.push_back(mkv(0,0,1,GB,0,0,0, 0,32'h80 ,0,I1,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 1,32'h80 ,0,I1,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,1,32'h91,0, 1,32'h80 ,0,I1,32'h4));
        tbl.push_back(mkv(0,0,0,0 ,0,0,0, 1,32'h90 ,0,I1,32'h4));

        // Bring both instances out of the unknown power-up state
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checking = 1'b1;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].data,
                          tbl[i].br, tbl[i].target, tbl[i].idr);
            checkVal($sformatf("tbl%0d_req_valid", i), {31'd0, pre_rv}, {31'd0, tbl[i].e_rv});
            checkVal($sformatf("tbl%0d_addr", i), pre_addr, tbl[i].e_addr);
            checkVal($sformatf("tbl%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_v});
            checkVal($sformatf("tbl%0d_if_instr", i), if_instr, tbl[i].e_instr);
            checkVal($sformatf("tbl%0d_if_pc4", i), if_pc4, tbl[i].e_pc4);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom % 200) == 0,
                          ($urandom % 2) == 0,
                          ($urandom % 3) == 0,
                          $urandom,
                          ($urandom % 16) == 0,
                          $urandom,
                          ($urandom % 2) == 0);
        end
        checking = 1'b0;

        // Wrap-around instance: first fetch at the top of memory, PC+4 wraps to 0
        @(negedge clk);
        w_reset = 1'b0; w_req_ready = 1'b1;
        #1;
        checkVal("wrap_req_valid0", {31'd0, w_req_valid}, 32'd1);
        checkVal("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = I2;
        @(posedge clk); #1;
        checkVal("wrap_if_valid", {31'd0, w_if_valid}, 32'd1);
        checkVal("wrap_if_pc4", w_if_pc4, 32'h0000_0000);
        checkVal("wrap_if_instr", w_if_instr, I2);
        @(negedge clk);
        w_rsp_valid = 1'b0; w_id_ready = 1'b1;
        #1;
        checkVal("wrap_addr_hold", w_addr, 32'h0000_0000);
        @(negedge clk);
        w_id_ready = 1'b0; w_req_ready = 1'b1;
        #1;
        checkVal("wrap_req_valid1", {31'd0, w_req_valid}, 32'd1);
        checkVal("wrap_addr1", w_addr, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-006 SHALL have port imem_addr  output  32  byte address of the requested word, equal to PC.
REQ-007 SHALL have port imem_rsp_valid  input  1  response word valid.
REQ-008 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-009 SHALL have port branch_taken  input  1  single-cycle redirect pulse.
REQ-010 SHALL have port branch_target  input  32  redirect address.
REQ-011 SHALL have port id_ready  input  1  decode/control stage accepts the held instruction.
REQ-012 SHALL have port if_valid  output  1  held instruction valid.
REQ-013 SHALL have port if_instr  output  32  held instruction.
REQ-014 SHALL have port if_opcode  output  6  if_instr[31:26], fed to the control unit's instruction input.
REQ-015 SHALL have port if_pc4  output  32  address of the held instruction plus 4.
REQ-016 SHALL have ports perf_fetched and perf_flushed  output  32 each  performance counters (see Configuration).

Function
REQ-017 SHALL implement states FETCH, WAIT, HOLD and DROP, with one outstanding memory request at most.
REQ-018 In FETCH: imem_req_valid=1 and imem_addr=PC; on imem_req_ready=1, go to WAIT.
REQ-019 In WAIT: on imem_rsp_valid=1, register if_instr=rsp_data, if_pc4=PC+4 and if_valid=1; set PC=PC+4; go to HOLD.
REQ-020 Latency: request accepted at edge N and response at edge N+k yield if_valid high from N+k+1.
REQ-021 In HOLD: if_valid and outputs stay stable while id_ready=0; when id_ready=1, clear if_valid at the next edge and go to FETCH.
REQ-022 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 On branch_taken=1: PC=branch_target with bits [1:0] forced to 0, and if_valid cleared at the same edge (flush).
REQ-024 Redirect in WAIT without rsp_valid, or in FETCH with a request handshake the same cycle, SHALL go to DROP.
REQ-025 In DROP: imem_req_valid=0; the next response is discarded, then go to FETCH.
REQ-026 Redirect in WAIT coinciding with rsp_valid: the response is discarded and the state goes to FETCH, not DROP.
REQ-027 Redirect in FETCH without a handshake, or in HOLD, SHALL go to FETCH at the new PC.
REQ-028 A redirect SHALL take priority over id_ready and over the response capture.

Reset
REQ-029 Reset SHALL set PC=RESET_PC, state FETCH, if_valid=0, if_instr=0, if_pc4=0 and both counters to 0.
REQ-030 imem_req_valid SHALL be 0 during any cycle with reset=1.
REQ-031 Reset mid-request SHALL abandon the outstanding response.
REQ-032 Any response arriving in the first FETCH after reset SHALL be ignored.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN defined: perf_fetched increments on each if_valid&&id_ready cycle.
REQ-034 Macro FETCH_PERF_CNT_EN defined: perf_flushed increments on each flushed held instruction and each discarded response.
REQ-035 Both counters SHALL wrap at 2^32.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: both counter ports SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-037 Shared package mips_pkg SHALL hold the state enum, the opcode field position constants (31:26), the word width (32) and the RESET_PC default.
REQ-038 One sub-module, fetch_perf_cnt, SHALL be instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-039 Reset, then memory with 1-cycle acceptance and rsp 2 cycles later, id_ready=1 -> addresses 0x0, 0x4, 0x8 in order; if_pc4 0x4, 0x8, 0xC; if_opcode=instr[31:26].
REQ-040 id_ready=0 for 5 cycles in HOLD -> if_instr and if_valid stable, no new imem request, PC unchanged.
REQ-041 branch_taken with target 0x0000_0103 while in WAIT -> next response discarded, next request address 0x0000_0100, perf_flushed +1 when enabled.
REQ-042 branch_taken coinciding with rsp_valid -> response discarded, no DROP cycle, next request at the target.
REQ-043 RESET_PC=32'hFFFF_FFFC -> first fetch at 0xFFFF_FFFC with if_pc4=0x0, second fetch at 0x0.
REQ-044 Assert reset while in WAIT -> PC=RESET_PC, if_valid=0 and imem_req_valid=0 that cycle; late response ignored.
